// File: rtl/lab1_pkg.sv
// Shared definitions for the lab1 built-in self-test controller.
package lab1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_SETTLE = 4;
    localparam int unsigned DEFAULT_STEP   = 2;

endpackage

// File: rtl/lab1_bist_ctrl_if.sv
// Control, stimulus and status bundle between the BIST controller and the lab1 logic under test.
interface lab1_bist_ctrl_if;

    logic       start;
    logic [7:0] swt_out;
    logic [7:0] led_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] first_fail;

    // master: the BIST controller; slave: the requester plus the lab1 logic being exercised
    modport master (
        input  start,
        input  led_in,
        output swt_out,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_fail
    );

    modport slave (
        output start,
        output led_in,
        input  swt_out,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_fail
    );

endinterface

// File: rtl/lab1_ref_model.sv
// Golden lab1 switch-to-LED function; purely combinational.
module lab1_ref_model (
    input  logic [7:0] swt,
    output logic [7:0] led
);

    logic e1;
    logic e3;

    assign e1  = swt[1] & ~swt[2];
    assign e3  = swt[2] & swt[3];
    assign led = {swt[7:4], e3, e1 | e3, e1, ~swt[0]};

endmodule

// File: rtl/lab1_bist_ctrl.sv
// Sweeps switch vectors 0, STEP, 2*STEP, ... into the lab1 logic and checks each LED response
// against the reference function after a settle delay.
module lab1_bist_ctrl
    import lab1_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE,
    parameter int unsigned STEP          = DEFAULT_STEP
) (
    input  logic             clk,
    input  logic             reset,
    lab1_bist_ctrl_if.master bus
);

    state_t     state;
    state_t     state_nx;
    logic [7:0] vec;
    logic [7:0] vec_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic [7:0] err;
    logic [7:0] err_nx;
    logic [7:0] ff;
    logic [7:0] ff_nx;
    logic [8:0] vec_next9;
    logic [7:0] exp_led;
    logic       mismatch;

    lab1_ref_model u_ref (
        .swt (vec),
        .led (exp_led)
    );

    // Nine bits so the step past 255 is seen as the end of the sweep rather than wrapping.
    assign vec_next9 = {1'b0, vec} + 9'(STEP);
    assign mismatch  = (bus.led_in != exp_led);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            vec   <= '0;
            cnt   <= '0;
            err   <= '0;
            ff    <= '0;
        end else begin
            state <= state_nx;
            vec   <= vec_nx;
            cnt   <= cnt_nx;
            err   <= err_nx;
            ff    <= ff_nx;
        end
    end

    always_comb begin
        state_nx = state;
        vec_nx   = vec;
        cnt_nx   = cnt;
        err_nx   = err;
        ff_nx    = ff;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_nx = ST_SETTLE;
                    vec_nx   = '0;
                    cnt_nx   = '0;
                    err_nx   = '0;
                    ff_nx    = '0;
                end
            end
            ST_SETTLE: begin
                cnt_nx = cnt + 8'd1;
                if (cnt == 8'(SETTLE_CYCLES - 1)) begin
                    state_nx = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (err != '1) begin
                        err_nx = err + 8'd1;
                    end
                    if (err == '0) begin
                        ff_nx = vec;
                    end
                end
                if (vec_next9[8]) begin
                    state_nx = ST_DONE;
                end else begin
                    state_nx = ST_SETTLE;
                    vec_nx   = vec_next9[7:0];
                    cnt_nx   = '0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus.swt_out    = vec;
    assign bus.busy       = (state == ST_SETTLE) || (state == ST_CHECK);
    assign bus.done       = (state == ST_DONE);
    assign bus.pass       = (state == ST_DONE) && (err == '0);
    assign bus.err_count  = err;
    assign bus.first_fail = ff;

endmodule

// File: tb/tb_lab1_bist_ctrl.sv
// Scoreboard bench: instance 0 uses default parameters, instance 1 uses STEP=1/SETTLE_CYCLES=1.
module tb_lab1_bist_ctrl;

    typedef struct {
        int cycles;
        int err;
        int ff;
        int pass;
        int nvec;
        int lastv;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [1:0] start_v;
    logic [1:0] busy_v;
    logic [1:0] done_v;
    logic [1:0] pass_v;
    logic [7:0] swt_v [2];
    logic [7:0] err_v [2];
    logic [7:0] ff_v  [2];

    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         lab_mode = 0;
    logic [7:0] xmask [256];
    exp_t       sbq0[$];
    exp_t       sbq1[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Lab1 behaviour stated bit by bit as arithmetic on the switch value.
    function automatic logic [7:0] golden(input int s);
        int e0;
        int e1;
        int e3;
        e0 = (s % 2 == 0) ? 1 : 0;
        e1 = ((s / 2) % 4 == 1) ? 1 : 0;
        e3 = ((s / 4) % 4 == 3) ? 1 : 0;
        return 8'((s / 16) * 16 + e3 * 8 + (((e1 + e3) > 0) ? 4 : 0) + e1 * 2 + e0);
    endfunction

    // What the attached lab1 logic returns for a held switch value.
    function automatic logic [7:0] lab_resp(input int g, input int v);
        if (g == 1) return 8'hFF;
        case (lab_mode)
            1:       return golden(v) & 8'hFB;
            2:       return golden(v) ^ xmask[v];
            default: return golden(v);
        endcase
    endfunction

    function automatic exp_t model(input int g);
        exp_t e;
        int   s;
        int   st;
        int   mism;
        s       = (g == 0) ? 4 : 1;
        st      = (g == 0) ? 2 : 1;
        mism    = 0;
        e.ff    = 0;
        e.nvec  = 0;
        e.lastv = 0;
        for (int v = 0; v <= 255; v += st) begin
            e.nvec++;
            e.lastv = v;
            if (lab_resp(g, v) != golden(v)) begin
                if (mism == 0) e.ff = v;
                mism++;
            end
        end
        e.err    = (mism > 255) ? 255 : mism;
        e.pass   = (mism == 0) ? 1 : 0;
        e.cycles = e.nvec * (s + 1);
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int S  = (g == 0) ? 4 : 1;
        localparam int ST = (g == 0) ? 2 : 1;

        lab1_bist_ctrl_if bus ();
        logic [7:0] glitch_v = 8'h00;
        int         t0 = 0;
        int         nseen = 0;
        int         lastv = 0;
        bit         seen [256];
        bit         pb = 1'b0;
        bit         pd = 1'b0;

        lab1_bist_ctrl #(
            .SETTLE_CYCLES (S),
            .STEP          (ST)
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        assign bus.start   = start_v[g];
        assign busy_v[g]   = bus.busy;
        assign done_v[g]   = bus.done;
        assign pass_v[g]   = bus.pass;
        assign swt_v[g]    = bus.swt_out;
        assign err_v[g]    = bus.err_count;
        assign ff_v[g]     = bus.first_fail;
        assign bus.led_in  = (g == 0 && lab_mode == 3) ? glitch_v : lab_resp(g, int'(bus.swt_out));

        // Monitor: tracks sweep start, observed vectors and compares against the scoreboard at done.
        always @(negedge clk) begin
            exp_t e;
            bit   have;
            if (reset) begin
                pb = 1'b0;
                pd = 1'b0;
            end else begin
                if (bus.busy && !pb) begin
                    t0    = cyc;
                    nseen = 0;
                    foreach (seen[i]) seen[i] = 1'b0;
                    chk($sformatf("u%0d.start_swt", g), int'(bus.swt_out), 0);
                    chk($sformatf("u%0d.start_err", g), int'(bus.err_count), 0);
                    chk($sformatf("u%0d.start_ff", g), int'(bus.first_fail), 0);
                    chk($sformatf("u%0d.start_done", g), int'(bus.done), 0);
                    chk($sformatf("u%0d.start_pass", g), int'(bus.pass), 0);
                end
                if (bus.busy) begin
                    if (!seen[bus.swt_out]) begin
                        seen[bus.swt_out] = 1'b1;
                        nseen++;
                    end
                    lastv = int'(bus.swt_out);
                    if ((cyc - t0 + 1) % (S + 1) == 0) glitch_v = golden(int'(bus.swt_out));
                    else glitch_v = 8'($urandom);
                end
                if (bus.done && !pd) begin
                    have = 1'b0;
                    if (g == 0) begin
                        if (sbq0.size() > 0) begin e = sbq0.pop_front(); have = 1'b1; end
                    end else begin
                        if (sbq1.size() > 0) begin e = sbq1.pop_front(); have = 1'b1; end
                    end
                    if (!have) begin
                        chk($sformatf("u%0d.unexpected_done", g), 1, 0);
                    end else begin
                        chk($sformatf("u%0d.elapsed", g), cyc - t0, e.cycles);
                        chk($sformatf("u%0d.err_count", g), int'(bus.err_count), e.err);
                        chk($sformatf("u%0d.first_fail", g), int'(bus.first_fail), e.ff);
                        chk($sformatf("u%0d.pass", g), int'(bus.pass), e.pass);
                        chk($sformatf("u%0d.busy_at_done", g), int'(bus.busy), 0);
                        chk($sformatf("u%0d.distinct_vectors", g), nseen, e.nvec);
                        chk($sformatf("u%0d.last_vector", g), lastv, e.lastv);
                    end
                end
                pb = bus.busy;
                pd = bus.done;
            end
        end
    end

    task automatic check_zero(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s.u%0d.swt_out", tag, g), int'(swt_v[g]), 0);
            chk($sformatf("%s.u%0d.busy", tag, g), int'(busy_v[g]), 0);
            chk($sformatf("%s.u%0d.done", tag, g), int'(done_v[g]), 0);
            chk($sformatf("%s.u%0d.pass", tag, g), int'(pass_v[g]), 0);
            chk($sformatf("%s.u%0d.err_count", tag, g), int'(err_v[g]), 0);
            chk($sformatf("%s.u%0d.first_fail", tag, g), int'(ff_v[g]), 0);
        end
    endtask

    task automatic do_start(input int g);
        @(negedge clk);
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
    endtask

    task automatic pulse_start(input int g);
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_v[g]) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL wait_done.u%0d: done still 0 after %0d cycles, required 1", g, budget);
    endtask

    task automatic run_sweep(input int g, input int mode);
        exp_t e;
        lab_mode = (g == 0) ? mode : 0;
        e = model(g);
        if (g == 0) sbq0.push_back(e);
        else sbq1.push_back(e);
        do_start(g);
        wait_done(g, e.cycles + 20);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        reset   = 1'b1;
        start_v = 2'b00;
        foreach (xmask[i]) xmask[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        run_sweep(0, 0);
        run_sweep(0, 1);
        for (int k = 0; k < 3; k++) begin
            foreach (xmask[i]) xmask[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_sweep(0, 2);
        end
        run_sweep(0, 3);

        // Start pulses mid-sweep must not restart or shift timing.
        lab_mode = 0;
        e = model(0);
        sbq0.push_back(e);
        do_start(0);
        repeat (5) @(negedge clk);
        pulse_start(0);
        repeat (94) @(negedge clk);
        pulse_start(0);
        repeat (199) @(negedge clk);
        pulse_start(0);
        wait_done(0, 700);
        repeat (2) @(negedge clk);

        // Asynchronous reset between edges partway through a sweep.
        do_start(0);
        repeat (199) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_zero("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_sweep(0, 0);

        run_sweep(1, 0);

        repeat (3) @(negedge clk);
        chk("sb0_leftover", sbq0.size(), 0);
        chk("sb1_leftover", sbq1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
